forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Pipeline control block that generates the 2-bit operand-select codes driving the two EX-stage 3-to-1 operand multiplexers (ALU source A and B). It also detects load-use hazards and stalls the front end. The block internally tracks the destination register, RegWrite and MemRead of the instructions in EX and MEM. Selectors are registered so they are valid for the whole cycle the consuming instruction sits in EX.

## Interface
- NRegBits, 5, width of register-specifier fields
- NCountBits, 16, width of the stall performance counter
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ID_Valid  in  1  instruction present in ID (0 = bubble)
- ID_Rs  in  NRegBits  source register A of the instruction in ID
- ID_Rt  in  NRegBits  source register B of the instruction in ID
- ID_WriteReg  in  NRegBits  destination register of the instruction in ID
- ID_RegWrite  in  1  instruction in ID writes the register file
- ID_MemRead  in  1  instruction in ID is a load
- Flush  in  1  kill the instruction in ID (taken branch/jump)
- Stall  out  1  hold PC and IF/ID; insert bubble into EX (combinational)
- ForwardA  out  2  operand A mux select: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result
- ForwardB  out  2  operand B mux select, same encoding
- StallCount  out  NCountBits  saturating count of stall cycles

## Operation
- Internal slots EX and MEM, each holding {WriteReg, RegWrite, MemRead}. Reset clears them to all zero.
- Each edge: MEM ← EX. EX ← ID fields, or a bubble when ID_Valid=0, Stall=1 or Flush=1. A bubble has RegWrite=0 and MemRead=0.
- Stall = ID_Valid & ~Flush & EX.MemRead & EX.RegWrite & (EX.WriteReg≠0) & (EX.WriteReg==ID_Rs | EX.WriteReg==ID_Rt).
- Forward select for operand X (Rs→A, Rt→B), latched at the edge the instruction moves ID→EX:
  - 10 if EX.RegWrite & EX.WriteReg≠0 & EX.WriteReg==X.
  - else 01 if MEM.RegWrite & MEM.WriteReg≠0 & MEM.WriteReg==X.
  - else 00.
  - EX has priority over MEM, because the EX slot holds the younger producer.
- When a bubble enters EX, ForwardA and ForwardB latch 00. Code 11 is never produced.
- Register 0 is never forwarded and never causes a stall.
- The register file is write-before-read, so a producer in WB needs neither forwarding nor a stall.
- StallCount increments on every edge where Stall=1 and saturates at all-ones.

## Timing
- Reset values: ForwardA=00, ForwardB=00, StallCount=0, Stall=0 (all slots are empty).
- Reset asserted mid-stall: Stall drops at once. After release, the held instruction re-enters normally.
- Stall is combinational from ID inputs and the EX slot, so it is valid in the same cycle.
- A load-use hazard produces exactly one stall cycle. On the next edge the load moves to MEM and the dependent instruction then latches select 01.
- Forward selects have 1-cycle latency: they are registered at the ID→EX edge and stable throughout EX.
- Flush and hazard in the same cycle: Flush wins, Stall=0, and a bubble enters EX.
- ID_Valid=0: Stall=0 and a bubble enters EX.

## Configuration
- FORWARDING_EN defined: behaviour exactly as above.
- FORWARDING_EN undefined:
  - ForwardA and ForwardB are tied to 00.
  - Stall asserts for any RAW match of ID_Rs or ID_Rt (nonzero) against the EX or MEM slot with RegWrite=1, regardless of MemRead.
  - An ALU producer in EX yields 2 stall cycles; a producer in MEM yields 1.
  - StallCount behaves identically.

## Test plan
- Reset asserted mid-stream, asynchronously between edges -> all outputs return to reset values immediately, with no clock edge required.
- add $8 then sub using Rs=$8 in the next cycle -> ForwardA=10 for sub in EX, Stall=0.
- add $8, unrelated, then or using Rt=$8 -> ForwardB=01 for or in EX.
- lw $9, then add using Rs=$9 -> exactly 1 cycle Stall=1, StallCount=1, then add latches ForwardA=01.
- Back-to-back add $8 / add $8 / sub with Rs=$8 -> ForwardA=10 (youngest wins). Writes to $0 followed by readers of $0 -> selects 00, no stall.
- Load-use hazard with Flush=1 in the same cycle -> Stall=0, bubble in EX. FORWARDING_EN undefined, add $8 then dependent -> 2 stall cycles, selects always 00.

Source files
------------

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage bus into the forwarding/hazard unit and its select/stall outputs.
interface forwarding_hazard_unit_if #(
    parameter int NRegBits   = 5,
    parameter int NCountBits = 16
);
    logic                  ID_Valid;
    logic [NRegBits-1:0]   ID_Rs;
    logic [NRegBits-1:0]   ID_Rt;
    logic [NRegBits-1:0]   ID_WriteReg;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  Flush;
    logic                  Stall;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic [NCountBits-1:0] StallCount;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
        input  Stall, ForwardA, ForwardB, StallCount
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
        output Stall, ForwardA, ForwardB, StallCount
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// EX operand forwarding selects, load-use stall and saturating stall counter.
// FORWARDING_EN defined: full forwarding; undefined: selects tied 00, stall on any RAW vs EX/MEM.
module forwarding_hazard_unit #(
    parameter int NRegBits   = 5,
    parameter int NCountBits = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    forwarding_hazard_unit_if.slave   bus
);
    logic [NRegBits-1:0]   ex_wr_q,  ex_wr_d;
    logic                  ex_rw_q,  ex_rw_d;
    logic                  ex_mr_q,  ex_mr_d;
    logic [NRegBits-1:0]   mem_wr_q;
    logic                  mem_rw_q;
    logic [NCountBits-1:0] cnt_q,    cnt_d;

    logic match_ex_rs, match_ex_rt, match_mem_rs, match_mem_rt;
    logic hazard, stall, bubble;

    always_comb begin
        match_ex_rs  = ex_rw_q  && (ex_wr_q  != '0) && (ex_wr_q  == bus.ID_Rs);
        match_ex_rt  = ex_rw_q  && (ex_wr_q  != '0) && (ex_wr_q  == bus.ID_Rt);
        match_mem_rs = mem_rw_q && (mem_wr_q != '0) && (mem_wr_q == bus.ID_Rs);
        match_mem_rt = mem_rw_q && (mem_wr_q != '0) && (mem_wr_q == bus.ID_Rt);
`ifdef FORWARDING_EN
        hazard = ex_mr_q && (match_ex_rs || match_ex_rt);
`else
        hazard = match_ex_rs || match_ex_rt || match_mem_rs || match_mem_rt;
`endif
        stall  = bus.ID_Valid && !bus.Flush && hazard;
        bubble = !bus.ID_Valid || bus.Flush || stall;

        ex_wr_d = bus.ID_WriteReg;
        ex_rw_d = bus.ID_RegWrite;
        ex_mr_d = bus.ID_MemRead;
        if (bubble) begin
            ex_wr_d = '0;
            ex_rw_d = 1'b0;
            ex_mr_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + NCountBits'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_wr_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_wr_q <= '0;
            mem_rw_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ex_wr_q  <= ex_wr_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            mem_wr_q <= ex_wr_q;
            mem_rw_q <= ex_rw_q;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    // EX slot is the younger producer, so it outranks MEM
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!bubble) begin
            if (match_ex_rs)       fwd_a_d = 2'b10;
            else if (match_mem_rs) fwd_a_d = 2'b01;
            if (match_ex_rt)       fwd_b_d = 2'b10;
            else if (match_mem_rt) fwd_b_d = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.ForwardA = fwd_a_q;
    assign bus.ForwardB = fwd_b_q;
`else
    assign bus.ForwardA = 2'b00;
    assign bus.ForwardB = 2'b00;
`endif

    assign bus.Stall      = stall;
    assign bus.StallCount = cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed table-driven bench for forwarding_hazard_unit, both FORWARDING_EN builds.
module tb_forwarding_hazard_unit;
    logic clk = 1'b0;
    logic reset;

    forwarding_hazard_unit_if #(.NRegBits(5), .NCountBits(16)) bus ();

    forwarding_hazard_unit #(.NRegBits(5), .NCountBits(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, wr;
        logic        rw, mr, fl;
        logic        st;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic fl,
                       input logic st, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] cnt);
        tbl.push_back('{v, rs, rt, wr, rw, mr, fl, st, fa, fb, cnt});
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic rw, input logic mr, input logic fl);
        bus.ID_Valid    = v;
        bus.ID_Rs       = rs;
        bus.ID_Rt       = rt;
        bus.ID_WriteReg = wr;
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.Flush       = fl;
    endtask

    initial begin
`ifdef FORWARDING_EN
        //   v  rs  rt  wr rw mr fl  st  fa     fb    cnt
        row(1,  1,  2,  8, 1, 0, 0,  0, 2'b00, 2'b00, 0); // add $8
        row(1,  8,  3, 10, 1, 0, 0,  0, 2'b10, 2'b00, 0); // sub uses $8 from EX
        row(1,  1,  2,  8, 1, 0, 0,  0, 2'b00, 2'b00, 0); // add $8
        row(1,  4,  5, 11, 1, 0, 0,  0, 2'b00, 2'b00, 0); // unrelated
        row(1,  6,  8, 12, 1, 0, 0,  0, 2'b00, 2'b01, 0); // or Rt=$8 from MEM
        row(1,  1,  2,  9, 1, 1, 0,  0, 2'b00, 2'b00, 0); // lw $9
        row(1,  9,  3, 13, 1, 0, 0,  1, 2'b00, 2'b00, 1); // load-use stall
        row(1,  9,  3, 13, 1, 0, 0,  0, 2'b01, 2'b00, 1); // re-issue, from MEM
        row(1,  1,  2,  8, 1, 0, 0,  0, 2'b00, 2'b00, 1); // add $8
        row(1,  3,  4,  8, 1, 0, 0,  0, 2'b00, 2'b00, 1); // add $8 again
        row(1,  8,  5, 14, 1, 0, 0,  0, 2'b10, 2'b00, 1); // youngest wins
        row(1,  1,  2,  0, 1, 0, 0,  0, 2'b00, 2'b00, 1); // write $0
        row(1,  3,  4,  0, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw $0
        row(1,  0,  0, 15, 1, 0, 0,  0, 2'b00, 2'b00, 1); // read $0
        row(1,  1,  2,  9, 1, 1, 0,  0, 2'b00, 2'b00, 1); // lw $9
        row(1,  9,  9, 16, 1, 0, 1,  0, 2'b00, 2'b00, 1); // hazard + flush
        row(1,  4,  9, 16, 1, 0, 0,  0, 2'b00, 2'b01, 1); // EX was bubble
        row(1,  1,  2, 17, 1, 0, 0,  0, 2'b00, 2'b00, 1); // add $17
        row(0, 17, 17, 20, 1, 1, 0,  0, 2'b00, 2'b00, 1); // invalid ID
        row(1, 17,  1, 18, 1, 0, 0,  0, 2'b01, 2'b00, 1); // $17 now in MEM
`else
        row(1,  1,  2,  8, 1, 0, 0,  0, 2'b00, 2'b00, 0); // add $8
        row(1,  8,  3, 10, 1, 0, 0,  1, 2'b00, 2'b00, 1); // EX producer: stall 1
        row(1,  8,  3, 10, 1, 0, 0,  1, 2'b00, 2'b00, 2); // MEM producer: stall 2
        row(1,  8,  3, 10, 1, 0, 0,  0, 2'b00, 2'b00, 2);
        row(1,  1,  2,  8, 1, 0, 0,  0, 2'b00, 2'b00, 2); // add $8
        row(1,  4,  5, 11, 1, 0, 0,  0, 2'b00, 2'b00, 2); // unrelated
        row(1,  6,  8, 12, 1, 0, 0,  1, 2'b00, 2'b00, 3); // MEM producer: 1 stall
        row(1,  6,  8, 12, 1, 0, 0,  0, 2'b00, 2'b00, 3);
        row(1,  1,  2,  9, 1, 1, 0,  0, 2'b00, 2'b00, 3); // lw $9
        row(1,  9,  3, 13, 1, 0, 0,  1, 2'b00, 2'b00, 4);
        row(1,  9,  3, 13, 1, 0, 0,  1, 2'b00, 2'b00, 5);
        row(1,  9,  3, 13, 1, 0, 0,  0, 2'b00, 2'b00, 5);
        row(1,  1,  2,  0, 1, 0, 0,  0, 2'b00, 2'b00, 5); // write $0
        row(1,  0,  0, 15, 1, 0, 0,  0, 2'b00, 2'b00, 5); // read $0
        row(1,  1,  2,  9, 1, 1, 0,  0, 2'b00, 2'b00, 5); // lw $9
        row(1,  9,  9, 16, 1, 0, 1,  0, 2'b00, 2'b00, 5); // hazard + flush
        row(1,  4,  9, 16, 1, 0, 0,  1, 2'b00, 2'b00, 6); // lw in MEM
        row(1,  4,  9, 16, 1, 0, 0,  0, 2'b00, 2'b00, 6);
        row(1,  1,  2, 17, 1, 0, 0,  0, 2'b00, 2'b00, 6); // add $17
        row(0, 17, 17, 20, 1, 1, 0,  0, 2'b00, 2'b00, 6); // invalid ID
        row(1, 17,  1, 18, 1, 0, 0,  1, 2'b00, 2'b00, 7); // $17 in MEM
        row(1, 17,  1, 18, 1, 0, 0,  0, 2'b00, 2'b00, 7);
`endif

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset Stall",      {31'd0, bus.Stall}, 32'd0);
        chk("reset ForwardA",   {30'd0, bus.ForwardA}, 32'd0);
        chk("reset ForwardB",   {30'd0, bus.ForwardB}, 32'd0);
        chk("reset StallCount", {16'd0, bus.StallCount}, 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].wr, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("row%0d Stall", i), {31'd0, bus.Stall}, {31'd0, tbl[i].st});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d ForwardA", i), {30'd0, bus.ForwardA}, {30'd0, tbl[i].fa});
            chk($sformatf("row%0d ForwardB", i), {30'd0, bus.ForwardB}, {30'd0, tbl[i].fb});
            chk($sformatf("row%0d StallCount", i), {16'd0, bus.StallCount}, {16'd0, tbl[i].cnt});
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(1, 1, 2, 9, 1, 1, 0);
        @(negedge clk);
        chk("areset lw Stall", {31'd0, bus.Stall}, 32'd0);
        @(posedge clk);
        #1;
        drive(1, 9, 3, 13, 1, 0, 0);
        @(negedge clk);
        chk("areset pre Stall", {31'd0, bus.Stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset Stall",      {31'd0, bus.Stall}, 32'd0);
        chk("areset ForwardA",   {30'd0, bus.ForwardA}, 32'd0);
        chk("areset ForwardB",   {30'd0, bus.ForwardB}, 32'd0);
        chk("areset StallCount", {16'd0, bus.StallCount}, 32'd0);
        reset = 1'b0;
        #1;
        chk("release Stall", {31'd0, bus.Stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("release ForwardA",   {30'd0, bus.ForwardA}, 32'd0);
        chk("release StallCount", {16'd0, bus.StallCount}, 32'd0);
        drive(1, 13, 4, 19, 1, 0, 0);
        @(negedge clk);
        chk("held dependent Stall", {31'd0, bus.Stall}, `ifdef FORWARDING_EN 32'd0 `else 32'd1 `endif);
        @(posedge clk);
        #1;
`ifdef FORWARDING_EN
        chk("held dependent ForwardA", {30'd0, bus.ForwardA}, 32'd2);
`else
        chk("held dependent StallCount", {16'd0, bus.StallCount}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
